// File: rtl/reg_write_demux.sv
// reg_write_demux
// Write-port distribution stage placed between the destination-register select
// mux and the register file. Requests (addr, data) are buffered in a small
// FIFO. The FIFO drains one entry per cycle into a registered one-hot write
// strobe with matching data. chk_hit lets hazard logic stall readers of any
// register that still has a write in flight.
//
// Build option: define REGW_ZERO_GUARD_EN to treat register 0 as hard-wired.
// Writes to it still occupy a slot and still produce out_valid, but the strobe
// stays all-zero and chk_addr=0 never hits. With the macro undefined, register
// 0 behaves like any other register.
//
// DEPTH must be 2 or 4. The pointer wrap relies on a power-of-two depth.

module reg_write_demux #(
  parameter  int ADDR_W   = 5,
  parameter  int DATA_W   = 32,
  parameter  int DEPTH    = 2,
  localparam int NUM_REGS = 2 ** ADDR_W,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                out_stall,
  output logic                out_valid,
  output logic [NUM_REGS-1:0] out_strobe,
  output logic [DATA_W-1:0]   out_data,
  input  logic [ADDR_W-1:0]   chk_addr,
  output logic                chk_hit,
  output logic [CNT_W-1:0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  // FIFO storage and bookkeeping
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Output register
  logic                out_valid_q, out_valid_d;
  logic [NUM_REGS-1:0] out_strobe_q, out_strobe_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;

  logic                push;
  logic                pop;
  logic [ADDR_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_data;
  logic [NUM_REGS-1:0] head_strobe;
  logic                hit;

  // in_ready comes from registered count only, so out_stall has no
  // combinational path to the upstream handshake. A push into an empty FIFO
  // is not poppable on the same edge because pop looks at count_q.
  assign in_ready  = (count_q != DEPTH_C);
  assign push      = in_valid && in_ready;
  assign pop       = (count_q != '0) && !out_stall;
  assign head_addr = addr_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Decode the head address into a one-hot register write enable
  always_comb begin
    head_strobe = '0;
    head_strobe[head_addr] = 1'b1;
`ifdef REGW_ZERO_GUARD_EN
    if (head_addr == '0) begin
      head_strobe = '0;
    end
`endif
  end

  // Next-state for the output register. out_data and the tracked address
  // hold across idle cycles. Only valid and strobe drop.
  always_comb begin
    out_valid_d  = pop;
    out_strobe_d = '0;
    out_data_d   = out_data_q;
    out_addr_d   = out_addr_q;
    if (pop) begin
      out_strobe_d = head_strobe;
      out_data_d   = head_data;
      out_addr_d   = head_addr;
    end
  end

  // Pending-write hit: any occupied FIFO slot, or the output register while
  // it is presenting a write
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((i < int'(count_q)) &&
          (addr_mem_q[rd_ptr_q + PTR_W'(i)] == chk_addr)) begin
        hit = 1'b1;
      end
    end
    if (out_valid_q && (out_addr_q == chk_addr)) begin
      hit = 1'b1;
    end
`ifdef REGW_ZERO_GUARD_EN
    if (chk_addr == '0) begin
      hit = 1'b0;
    end
`endif
  end

  // Entry storage needs no reset: slots are only observed while count covers them
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= in_addr;
      data_mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Control and output state; async reset drops buffered writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_strobe_q <= '0;
      out_data_q   <= '0;
      out_addr_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_strobe_q <= out_strobe_d;
      out_data_q   <= out_data_d;
      out_addr_q   <= out_addr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_strobe = out_strobe_q;
  assign out_data   = out_data_q;
  assign count      = count_q;
  assign chk_hit    = hit;

endmodule
